// File: rtl/sr_pkg.sv
// Shared flag definitions for the status register and the condition-check stage.
// Flag order {z,c,n,v} is fixed here once and reused everywhere.
package sr_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam flags_t SR_RESET = '0;

  // Masked flag update: bits with mask=1 take the new value, others keep the old one.
  function automatic flags_t merge_flags(flags_t cur, flags_t upd, flags_t mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

endpackage

// File: rtl/status_register_if.sv
// Signal bundle between the execute stage and the status register.
// No handshake: every input is sampled on every rising clock edge and there are no stalls.
interface status_register_if #(parameter int STACK_DEPTH = 4);
  import sr_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               flush;
  logic               alu_valid;
  logic               s_bit;
  logic               cond_pass;
  flags_t             alu_flags;
  flags_t             alu_mask;
  logic               wr_en;
  flags_t             wr_data;
  logic               push;
  logic               pop;
  logic               err_clr;

  flags_t             sr;
  flags_t             sr_next;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               err;

  modport master (
    output flush, alu_valid, s_bit, cond_pass, alu_flags, alu_mask,
           wr_en, wr_data, push, pop, err_clr,
    input  sr, sr_next, depth, stack_full, stack_empty, err
  );

  modport slave (
    input  flush, alu_valid, s_bit, cond_pass, alu_flags, alu_mask,
           wr_en, wr_data, push, pop, err_clr,
    output sr, sr_next, depth, stack_full, stack_empty, err
  );

endinterface

// File: rtl/sr_stack.sv
// Small LIFO of saved flag values used on exception entry/return.
// Callers present only legal push/pop requests; the guards here just keep depth in range.
module sr_stack
  import sr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  flags_t mem [DEPTH];

  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= SR_RESET;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth == DW'(i)) mem[i] <= din;
      end
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

  // Entry at depth-1 is the most recently saved value.
  always_comb begin
    top = SR_RESET;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) top = mem[i];
    end
  end

endmodule

// File: rtl/status_register.sv
// Processor status flags {z,c,n,v}: ALU / explicit-write / exception-restore sources,
// with a saved-flag LIFO and a sticky misuse error.
module status_register
  import sr_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  status_register_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  flags_t        sr_q;
  flags_t        sr_d;
  flags_t        stack_top;
  logic          err_q;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic          alu_upd;
  logic          err_set;

  // Simultaneous push and pop is treated as misuse: neither request is honoured.
  assign push_req = bus.push & ~bus.pop;
  assign pop_req  = bus.pop & ~bus.push;
  assign push_ok  = push_req & ~full;
  assign pop_ok   = pop_req & ~empty;
  assign err_set  = (bus.push & bus.pop) | (push_req & full) | (pop_req & empty);
  assign alu_upd  = bus.alu_valid & bus.s_bit & bus.cond_pass & ~bus.flush;

  sr_stack #(.DEPTH(STACK_DEPTH), .DW(DW)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (sr_q),
    .top   (stack_top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sr_d = sr_q;
    if (pop_ok)          sr_d = stack_top;
    else if (bus.wr_en)  sr_d = bus.wr_data;
    else if (alu_upd)    sr_d = merge_flags(sr_q, bus.alu_flags, bus.alu_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= SR_RESET;
      err_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      if (err_set)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.sr          = sr_q;
  assign bus.sr_next     = sr_d;
  assign bus.depth       = depth;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_status_register.sv
// Directed bench for status_register: a queue-based flag model checked every cycle,
// plus hand-computed literal expectations from the test plan.
module tb_status_register;
  import sr_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  status_register_if #(.STACK_DEPTH(D)) bus ();

  status_register #(.STACK_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  flags_t m_sr;
  logic   m_err;
  flags_t stk_q[$];

  function automatic flags_t calc_next_sr();
    flags_t r;
    logic   legal_alu;
    legal_alu = bus.alu_valid && bus.s_bit && bus.cond_pass && !bus.flush;
    r = m_sr;
    if (bus.pop && !bus.push && stk_q.size() > 0) begin
      r = stk_q[stk_q.size() - 1];
    end else if (bus.wr_en) begin
      r = bus.wr_data;
    end else if (legal_alu) begin
      for (int b = 0; b < 4; b++) r[b] = bus.alu_mask[b] ? bus.alu_flags[b] : m_sr[b];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sr  = '0;
      m_err = 1'b0;
      stk_q.delete();
    end else begin
      flags_t nsr;
      logic   eset;
      nsr  = calc_next_sr();
      eset = 1'b0;
      if (bus.push && bus.pop) eset = 1'b1;
      else if (bus.push) begin
        if (stk_q.size() < D) stk_q.push_back(m_sr);
        else eset = 1'b1;
      end else if (bus.pop) begin
        if (stk_q.size() > 0) void'(stk_q.pop_back());
        else eset = 1'b1;
      end
      if (eset) m_err = 1'b1;
      else if (bus.err_clr) m_err = 1'b0;
      m_sr = nsr;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("sr_model",      32'(bus.sr),          32'(m_sr));
      check("sr_next_model", 32'(bus.sr_next),     32'(calc_next_sr()));
      check("depth_model",   32'(bus.depth),       32'(stk_q.size()));
      check("full_model",    32'(bus.stack_full),  32'(stk_q.size() == D));
      check("empty_model",   32'(bus.stack_empty), 32'(stk_q.size() == 0));
      check("err_model",     32'(bus.err),         32'(m_err));
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    bus.flush = 0; bus.alu_valid = 0; bus.s_bit = 0; bus.cond_pass = 0;
    bus.alu_flags = '0; bus.alu_mask = '0; bus.wr_en = 0; bus.wr_data = '0;
    bus.push = 0; bus.pop = 0; bus.err_clr = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input flags_t f, input flags_t m, input logic cp, input logic fl);
    bus.alu_valid = 1; bus.s_bit = 1; bus.cond_pass = cp; bus.flush = fl;
    bus.alu_flags = f; bus.alu_mask = m;
  endtask

  task automatic write(input flags_t d);
    bus.wr_en = 1; bus.wr_data = d;
  endtask

  flags_t saved [4];

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_sr",    32'(bus.sr), 32'h0);
    check("rst_depth", 32'(bus.depth), 32'h0);
    check("rst_empty", 32'(bus.stack_empty), 32'h1);
    check("rst_full",  32'(bus.stack_full), 32'h0);
    check("rst_err",   32'(bus.err), 32'h0);

    // ALU full-mask update
    alu(4'b1010, 4'b1111, 1, 0);
    #1 check("alu_sr_next", 32'(bus.sr_next), 32'b1010);
    cycle(); idle();
    check("alu_sr", 32'(bus.sr), 32'b1010);

    // Masked update, gated by cond_pass and flush
    write(4'b1111); cycle(); idle();
    alu(4'b0000, 4'b1010, 0, 0); cycle(); idle();
    check("cond_fail_hold", 32'(bus.sr), 32'b1111);
    alu(4'b0000, 4'b1010, 1, 1); cycle(); idle();
    check("flush_hold", 32'(bus.sr), 32'b1111);
    alu(4'b0000, 4'b1010, 1, 0); cycle(); idle();
    check("mask_sr", 32'(bus.sr), 32'b0101);
    bus.flush = 1; write(4'b0110); cycle(); idle();
    check("flush_wr", 32'(bus.sr), 32'b0110);

    // Push/pop with concurrent writes
    write(4'b0011); cycle(); idle();
    bus.push = 1; write(4'b1000); cycle(); idle();
    check("push_wr_sr",    32'(bus.sr), 32'b1000);
    check("push_wr_depth", 32'(bus.depth), 32'd1);
    bus.pop = 1; write(4'b0001); cycle(); idle();
    check("pop_wr_sr",    32'(bus.sr), 32'b0011);
    check("pop_wr_depth", 32'(bus.depth), 32'd0);

    // Fill, overflow, drain, underflow
    saved[0] = 4'b0011; saved[1] = 4'b0001; saved[2] = 4'b0010; saved[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      bus.push = 1;
      write((i == 3) ? 4'b1000 : saved[i + 1]);
      cycle(); idle();
    end
    check("full4", 32'(bus.stack_full), 32'h1);
    bus.push = 1; cycle(); idle();
    check("ovf_depth", 32'(bus.depth), 32'd4);
    check("ovf_err",   32'(bus.err), 32'h1);
    for (int i = 3; i >= 0; i--) begin
      bus.pop = 1; cycle(); idle();
      check("lifo_sr", 32'(bus.sr), 32'(saved[i]));
    end
    bus.pop = 1; cycle(); idle();
    check("udf_depth", 32'(bus.depth), 32'd0);
    check("udf_err",   32'(bus.err), 32'h1);
    check("udf_sr",    32'(bus.sr), 32'b0011);
    bus.err_clr = 1; cycle(); idle();
    check("err_clr", 32'(bus.err), 32'h0);

    // push & pop together at depth 2
    bus.push = 1; cycle(); bus.push = 1; cycle(); idle();
    bus.push = 1; bus.pop = 1; alu(4'b1100, 4'b1111, 1, 0); cycle(); idle();
    check("pp_depth", 32'(bus.depth), 32'd2);
    check("pp_err",   32'(bus.err), 32'h1);
    check("pp_sr",    32'(bus.sr), 32'b1100);
    bus.err_clr = 1; bus.push = 1; bus.pop = 1; cycle(); idle();
    check("err_set_dom", 32'(bus.err), 32'h1);
    bus.err_clr = 1; cycle(); idle();

    // Asynchronous reset between edges
    bus.push = 1; write(4'b1111); cycle(); idle();
    check("pre_rst_depth", 32'(bus.depth), 32'd3);
    check("pre_rst_sr",    32'(bus.sr), 32'b1111);
    #1 rst = 1;
    #1;
    check("arst_sr",    32'(bus.sr), 32'h0);
    check("arst_depth", 32'(bus.depth), 32'd0);
    check("arst_empty", 32'(bus.stack_empty), 32'h1);
    cycle(); rst = 0;
    bus.pop = 1; cycle(); idle();
    check("post_rst_pop_err", 32'(bus.err), 32'h1);
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
